// File: rtl/multicycle_sequencer_pkg.sv
// Shared state and trap-cause encodings for the multi-cycle sequencer and its debug logic.
package multicycle_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_EXECUTE = 3'b011,
    ST_MEMORY  = 3'b100,
    ST_WRITE   = 3'b101,
    ST_TRAP    = 3'b110,
    ST_HALT    = 3'b111
  } state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_IMEM_TO = 2'b01,
    CAUSE_DMEM_TO = 2'b10,
    CAUSE_ILLEGAL = 2'b11
  } cause_e;

  // States that wait on a memory ack and are subject to the bus timeout.
  function automatic logic is_mem_wait(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMORY);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the sequencer and the rest of the core.
//  master: sequencer side (consumes run/stall/acks/decode flags, drives enables, reqs, debug).
//  slave : core/memory side (the mirror image).
interface multicycle_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  import multicycle_sequencer_pkg::*;

  logic                 run;
  logic                 stall;
  logic                 imem_ack;
  logic                 dmem_ack;
  logic                 need_mem;
  logic                 reg_write;
  logic                 illegal;
  logic                 trap_clear;

  logic                 if_en;
  logic                 id_en;
  logic                 exe_en;
  logic                 mem_en;
  logic                 pc_en;
  logic                 wb_en;
  logic                 imem_req;
  logic                 dmem_req;
  logic [STATE_W-1:0]   state;
  logic                 trap;
  logic [CAUSE_W-1:0]   trap_cause;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  run, stall, imem_ack, dmem_ack, need_mem, reg_write, illegal, trap_clear,
    output if_en, id_en, exe_en, mem_en, pc_en, wb_en, imem_req, dmem_req,
           state, trap, trap_cause, retired
  );

  modport slave (
    output run, stall, imem_ack, dmem_ack, need_mem, reg_write, illegal, trap_clear,
    input  if_en, id_en, exe_en, mem_en, pc_en, wb_en, imem_req, dmem_req,
           state, trap, trap_cause, retired
  );

endinterface

// File: rtl/multicycle_sequencer_seq_wait_timer.sv
// Memory-wait timer: counts non-ack cycles, flags the last allowed cycle.
//  clk, rst  : clock, async active-high reset
//  clear_i   : zero the counter (takes priority over count_i)
//  count_i   : waiting on an ack this cycle
//  timeout_c : combinational; this waiting cycle is the MEM_TIMEOUT-th without an ack
module seq_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic timeout_c
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only raised on a non-ack cycle, so an ack on the last cycle always wins.
  assign timeout_c = (MEM_TIMEOUT != 0) && count_i && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXECUTE/[MEMORY]/WRITE with
// req/ack memory handshakes, bus timeout, illegal-instruction trap, stall and a
// retired-instruction counter.
//  clk, rst : clock, async active-high reset
//  bus      : master modport; run/stall/acks/decode flags in, stage enables,
//             memory requests, state/trap/trap_cause/retired out.
// Enables and requests are decodes of the registered state; trap_cause and
// retired are registers.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
);

  state_e               state_q;
  state_e               state_d;
  cause_e               cause_q;
  cause_e               cause_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic [CNT_WIDTH-1:0] retired_d;

  logic                 wait_count;
  logic                 wait_clear;
  logic                 timeout_c;

  // Count only cycles spent waiting for an ack; any transition restarts the count.
  assign wait_count = is_mem_wait(state_q) &&
                      !((state_q == ST_FETCH) ? bus.imem_ack : bus.dmem_ack);
  assign wait_clear = (state_d != state_q);

  seq_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wait_clear),
    .count_i   (wait_count),
    .timeout_c (timeout_c)
  );

  // Next state, trap cause and retire count.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    case (state_q)
      ST_HALT: begin
        if (bus.run) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          state_d = ST_DECODE;
        end else if (timeout_c) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (!bus.stall) begin
          if (bus.illegal) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = ST_EXECUTE;
          end
        end
      end
      ST_EXECUTE: begin
        if (!bus.stall) state_d = bus.need_mem ? ST_MEMORY : ST_WRITE;
      end
      ST_MEMORY: begin
        if (bus.dmem_ack) begin
          state_d = ST_WRITE;
        end else if (timeout_c) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      ST_WRITE: begin
        if (!bus.stall) begin
          retired_d = retired_q + CNT_WIDTH'(1);
          state_d   = bus.run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_TRAP: begin
        if (bus.trap_clear) begin
          state_d = ST_HALT;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HALT;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  // Stage enables and requests, zero latency from state.
  assign bus.if_en      = (state_q == ST_FETCH);
  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.id_en      = (state_q == ST_DECODE)  && !bus.stall;
  assign bus.exe_en     = (state_q == ST_EXECUTE) && !bus.stall;
  assign bus.mem_en     = (state_q == ST_MEMORY);
  assign bus.dmem_req   = (state_q == ST_MEMORY);
  assign bus.pc_en      = (state_q == ST_WRITE)   && !bus.stall;
  assign bus.wb_en      = (state_q == ST_WRITE)   && !bus.stall && bus.reg_write;
  assign bus.trap       = (state_q == ST_TRAP);
  assign bus.state      = state_q;
  assign bus.trap_cause = cause_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MEM_TIMEOUT=15, CNT_WIDTH=4).
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CW      = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   n;

  multicycle_sequencer_if #(.CNT_WIDTH(CW)) bus ();

  multicycle_sequencer #(
    .MEM_TIMEOUT (TIMEOUT),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.run = 1'b0;  bus.stall = 1'b0;    bus.imem_ack = 1'b0;  bus.dmem_ack = 1'b0;
    bus.need_mem = 1'b0; bus.reg_write = 1'b0; bus.illegal = 1'b0; bus.trap_clear = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;

    // Reset values
    chk("rst_state", 32'(bus.state), 32'(ST_HALT));
    chk("rst_cause", 32'(bus.trap_cause), 32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    chk("rst_if_en", 32'(bus.if_en), 32'd0);
    chk("rst_trap", 32'(bus.trap), 32'd0);
    rst = 1'b0;

    // 1: simple 4-stage instruction with immediate acks
    bus.run = 1'b1; bus.imem_ack = 1'b1; bus.reg_write = 1'b1;
    tick(); chk("t1_idle", 32'(bus.state), 32'(ST_IDLE));
    tick(); chk("t1_fetch", 32'(bus.state), 32'(ST_FETCH));
    chk("t1_imem_req", 32'(bus.imem_req), 32'd1);
    chk("t1_if_en", 32'(bus.if_en), 32'd1);
    tick(); chk("t1_decode", 32'(bus.state), 32'(ST_DECODE));
    chk("t1_id_en", 32'(bus.id_en), 32'd1);
    tick(); chk("t1_execute", 32'(bus.state), 32'(ST_EXECUTE));
    chk("t1_exe_en", 32'(bus.exe_en), 32'd1);
    tick(); chk("t1_write", 32'(bus.state), 32'(ST_WRITE));
    chk("t1_pc_en", 32'(bus.pc_en), 32'd1);
    chk("t1_wb_en", 32'(bus.wb_en), 32'd1);
    chk("t1_ret_pre", 32'(bus.retired), 32'd0);
    tick(); chk("t1_refetch", 32'(bus.state), 32'(ST_FETCH));
    chk("t1_pc_en_off", 32'(bus.pc_en), 32'd0);
    chk("t1_retired", 32'(bus.retired), 32'd1);

    // 2: load/store with dmem ack on the third MEMORY cycle
    bus.need_mem = 1'b1; bus.dmem_ack = 1'b0;
    tick(); tick(); tick();
    chk("t2_memory", 32'(bus.state), 32'(ST_MEMORY));
    chk("t2_mem_en", 32'(bus.mem_en), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.dmem_req) n++;
      bus.dmem_ack = (n == 3);
      if (bus.state != ST_MEMORY) break;
      tick();
    end
    chk("t2_req_cycles", 32'(n), 32'd3);
    chk("t2_write", 32'(bus.state), 32'(ST_WRITE));
    chk("t2_pc_en", 32'(bus.pc_en), 32'd1);
    bus.need_mem = 1'b0;
    tick(); chk("t2_retired", 32'(bus.retired), 32'd2);
    chk("t2_pc_en_off", 32'(bus.pc_en), 32'd0);

    // 3: imem timeout after 15 FETCH cycles, then clear, then ack on cycle 15
    bus.imem_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.state != ST_FETCH) break;
      n++;
      tick();
    end
    chk("t3_fetch_cycles", 32'(n), 32'(TIMEOUT));
    chk("t3_trap_state", 32'(bus.state), 32'(ST_TRAP));
    chk("t3_trap", 32'(bus.trap), 32'd1);
    chk("t3_cause", 32'(bus.trap_cause), 32'd1);
    chk("t3_imem_req_off", 32'(bus.imem_req), 32'd0);
    tick(); chk("t3_trap_hold", 32'(bus.trap_cause), 32'd1);
    bus.trap_clear = 1'b1;
    tick(); chk("t3_halt", 32'(bus.state), 32'(ST_HALT));
    chk("t3_cause_clr", 32'(bus.trap_cause), 32'd0);
    chk("t3_trap_off", 32'(bus.trap), 32'd0);
    bus.trap_clear = 1'b0;
    tick(); tick();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.state != ST_FETCH) break;
      n++;
      bus.imem_ack = (n == int'(TIMEOUT));
      tick();
    end
    chk("t3_ack_cycles", 32'(n), 32'(TIMEOUT));
    chk("t3_ack_wins", 32'(bus.state), 32'(ST_DECODE));
    chk("t3_no_trap", 32'(bus.trap), 32'd0);

    // 4: illegal instruction trap
    bus.illegal = 1'b1;
    tick(); chk("t4_ill_state", 32'(bus.state), 32'(ST_TRAP));
    chk("t4_ill_cause", 32'(bus.trap_cause), 32'd3);
    chk("t4_ill_pc_en", 32'(bus.pc_en), 32'd0);
    chk("t4_ill_wb_en", 32'(bus.wb_en), 32'd0);
    bus.illegal = 1'b0; bus.trap_clear = 1'b1;
    tick(); bus.trap_clear = 1'b0;
    tick(); tick(); tick();
    chk("t4_decode", 32'(bus.state), 32'(ST_DECODE));
    bus.stall = 1'b1;
    #1 chk("t4_id_stall", 32'(bus.id_en), 32'd0);
    tick(); chk("t4_dec_hold", 32'(bus.state), 32'(ST_DECODE));
    bus.stall = 1'b0;
    #1 chk("t4_id_go", 32'(bus.id_en), 32'd1);
    tick(); tick();
    chk("t4_write", 32'(bus.state), 32'(ST_WRITE));
    bus.stall = 1'b1; bus.reg_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_wr_hold", 32'(bus.state), 32'(ST_WRITE));
      chk("t4_pc_stall", 32'(bus.pc_en), 32'd0);
      chk("t4_ret_stall", 32'(bus.retired), 32'd2);
      tick();
    end
    bus.stall = 1'b0;
    #1 chk("t4_pc_go", 32'(bus.pc_en), 32'd1);
    chk("t4_wb_noreg", 32'(bus.wb_en), 32'd0);
    tick(); chk("t4_retired", 32'(bus.retired), 32'd3);
    chk("t4_refetch", 32'(bus.state), 32'(ST_FETCH));
    bus.reg_write = 1'b1;

    // 5: wrap of 4-bit counter after 17 retires, then run=0 parks in IDLE
    for (int k = 0; k < 14; k++) begin
      repeat (4) tick();
    end
    chk("t5_wrap", 32'(bus.retired), 32'd1);
    chk("t5_fetch", 32'(bus.state), 32'(ST_FETCH));
    bus.run = 1'b0;
    tick(); tick(); tick();
    chk("t5_write", 32'(bus.state), 32'(ST_WRITE));
    chk("t5_pc_en", 32'(bus.pc_en), 32'd1);
    tick(); chk("t5_idle", 32'(bus.state), 32'(ST_IDLE));
    chk("t5_retired", 32'(bus.retired), 32'd2);
    tick(); chk("t5_park", 32'(bus.state), 32'(ST_IDLE));

    // 6: dmem timeout, then async reset from TRAP and from mid-MEMORY
    bus.run = 1'b1; bus.need_mem = 1'b1; bus.dmem_ack = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t6_memory", 32'(bus.state), 32'(ST_MEMORY));
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.state != ST_MEMORY) break;
      n++;
      tick();
    end
    chk("t6_mem_cycles", 32'(n), 32'(TIMEOUT));
    chk("t6_dmem_cause", 32'(bus.trap_cause), 32'd2);
    rst = 1'b1;
    #1 chk("t6_rst_cause", 32'(bus.trap_cause), 32'd0);
    chk("t6_rst_state", 32'(bus.state), 32'(ST_HALT));
    chk("t6_rst_retired", 32'(bus.retired), 32'd0);
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("t6_mem_req", 32'(bus.dmem_req), 32'd1);
    rst = 1'b1;
    #1 chk("t6_req_drop", 32'(bus.dmem_req), 32'd0);
    chk("t6_mem_en_drop", 32'(bus.mem_en), 32'd0);
    chk("t6_state_drop", 32'(bus.state), 32'(ST_HALT));
    rst = 1'b0;
    tick(); chk("t6_idle_again", 32'(bus.state), 32'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
